// File: rtl/dummy_rtl_dma64_pkg.sv
// Shared types and constants for the 64-bit dummy accelerator load/store sequencer.
package dummy_rtl_dma64_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_DATA,
        S_DONE
    } state_t;

    localparam logic [2:0] DMA_SIZE_64 = 3'b011;

    // Width of a counter that must hold 0..burst_beats inclusive.
    function automatic int beat_cnt_w(input int burst_beats);
        return $clog2(burst_beats + 1);
    endfunction

endpackage

// File: rtl/dummy_rtl_dma64_fifo.sv
// Synchronous first-word fall-through FIFO holding one DMA burst between read and write-back.
module dummy_rtl_dma64_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; only the pointers do, so the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dummy_rtl_dma64_seq.sv
// Load/store sequencer: splits a copy of conf_info_size words into bounded read bursts,
// buffers each burst, and writes it back to the region directly after the input.
module dummy_rtl_dma64_seq
    import dummy_rtl_dma64_pkg::*;
#(
    parameter int BURST_BEATS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] conf_info_size,
    input  logic        conf_done,
    output logic        dma_read_ctrl_valid,
    input  logic        dma_read_ctrl_ready,
    output logic [31:0] dma_read_ctrl_data_index,
    output logic [31:0] dma_read_ctrl_data_length,
    output logic [2:0]  dma_read_ctrl_data_size,
    input  logic        dma_read_chnl_valid,
    output logic        dma_read_chnl_ready,
    input  logic [63:0] dma_read_chnl_data,
    output logic        dma_write_ctrl_valid,
    input  logic        dma_write_ctrl_ready,
    output logic [31:0] dma_write_ctrl_data_index,
    output logic [31:0] dma_write_ctrl_data_length,
    output logic [2:0]  dma_write_ctrl_data_size,
    output logic        dma_write_chnl_valid,
    input  logic        dma_write_chnl_ready,
    output logic [63:0] dma_write_chnl_data,
    output logic        acc_done,
    output logic [31:0] debug
);

    localparam int          CNT_W     = beat_cnt_w(BURST_BEATS);
    localparam logic [31:0] BURST_LEN = 32'(BURST_BEATS);

    state_t             state;
    state_t             state_next;
    logic               conf_done_q;
    logic               conf_done_qq;
    logic               start;
    logic [31:0]        total;
    logic [31:0]        offset;
    logic [31:0]        remain;
    logic [31:0]        len;
    logic [CNT_W-1:0]   beat_cnt;
    logic               burst_last;
    logic               rd_ctrl_hs;
    logic               rd_beat;
    logic               wr_ctrl_hs;
    logic               wr_beat;
    logic               fifo_full;
    logic               fifo_empty;
    logic [63:0]        fifo_head;

    // Edge detect runs on the registered copy of conf_done, costing one cycle of start latency.
    assign start      = conf_done_q && !conf_done_qq;
    assign remain     = total - offset;
    assign len        = (remain < BURST_LEN) ? remain : BURST_LEN;
    assign burst_last = ((32'(beat_cnt) + 32'd1) == len);

    assign rd_ctrl_hs = dma_read_ctrl_valid && dma_read_ctrl_ready;
    assign rd_beat    = dma_read_chnl_valid && dma_read_chnl_ready;
    assign wr_ctrl_hs = dma_write_ctrl_valid && dma_write_ctrl_ready;
    assign wr_beat    = dma_write_chnl_valid && dma_write_chnl_ready;

    assign dma_read_ctrl_data_size  = DMA_SIZE_64;
    assign dma_write_ctrl_data_size = DMA_SIZE_64;
    assign dma_read_chnl_ready      = (state == S_RD_DATA) && !fifo_full;
    assign dma_write_chnl_valid     = (state == S_WR_DATA) && !fifo_empty;
    assign dma_write_chnl_data      = dma_write_chnl_valid ? fifo_head : '0;

    dummy_rtl_dma64_fifo #(
        .DEPTH (BURST_BEATS),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       ((state == S_IDLE) && start),
        .push      (rd_beat),
        .push_data (dma_read_chnl_data),
        .pop       (wr_beat),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: state_next gets its default first, so every path assigns it and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = (conf_info_size == '0) ? S_DONE : S_RD_REQ;
            S_RD_REQ:  if (rd_ctrl_hs) state_next = S_RD_DATA;
            S_RD_DATA: if (rd_beat && burst_last) state_next = S_WR_REQ;
            S_WR_REQ:  if (wr_ctrl_hs) state_next = S_WR_DATA;
            S_WR_DATA: if (wr_beat && burst_last)
                           state_next = ((offset + len) == total) ? S_DONE : S_RD_REQ;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conf_done_q                <= 1'b0;
            conf_done_qq               <= 1'b0;
            total                      <= '0;
            offset                     <= '0;
            beat_cnt                   <= '0;
            debug                      <= '0;
            acc_done                   <= 1'b0;
            dma_read_ctrl_valid        <= 1'b0;
            dma_read_ctrl_data_index   <= '0;
            dma_read_ctrl_data_length  <= '0;
            dma_write_ctrl_valid       <= 1'b0;
            dma_write_ctrl_data_index  <= '0;
            dma_write_ctrl_data_length <= '0;
        end else begin
            conf_done_q  <= conf_done;
            conf_done_qq <= conf_done_q;
            acc_done     <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        total    <= conf_info_size;
                        offset   <= '0;
                        debug    <= '0;
                        beat_cnt <= '0;
                    end
                end
                // Ctrl fields load together with valid and hold until the handshake.
                S_RD_REQ: begin
                    if (!dma_read_ctrl_valid) begin
                        dma_read_ctrl_valid       <= 1'b1;
                        dma_read_ctrl_data_index  <= offset;
                        dma_read_ctrl_data_length <= len;
                    end else if (dma_read_ctrl_ready) begin
                        dma_read_ctrl_valid <= 1'b0;
                    end
                end
                S_RD_DATA: begin
                    if (rd_beat) beat_cnt <= burst_last ? '0 : beat_cnt + CNT_W'(1);
                end
                S_WR_REQ: begin
                    if (!dma_write_ctrl_valid) begin
                        dma_write_ctrl_valid       <= 1'b1;
                        dma_write_ctrl_data_index  <= total + offset;
                        dma_write_ctrl_data_length <= len;
                    end else if (dma_write_ctrl_ready) begin
                        dma_write_ctrl_valid <= 1'b0;
                    end
                end
                S_WR_DATA: begin
                    if (wr_beat) begin
                        if (burst_last) begin
                            beat_cnt <= '0;
                            offset   <= offset + len;
                            debug    <= debug + 32'd1;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
